// File: rtl/or_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : or_seq_checker
// Purpose  : Synthesizable monitor for  $rose(start) |-> seq1 or seq2
//            seq1 = a[*A_LEN]
//            seq2 = !b[*B_LOW] ##1 b[*B_HIGH]
//            Produces registered pass/fail pulses plus saturating counters
//            of passes, fails and triggers dropped while busy.
// Revision : 1.0  initial release
// ============================================================================
module or_seq_checker #(
   parameter int A_LEN  = 2,
   parameter int B_LOW  = 3,
   parameter int B_HIGH = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int B_LEN = B_LOW + B_HIGH;
   localparam int I1_W  = $clog2(A_LEN) + 1;
   localparam int I2_W  = $clog2(B_LEN) + 1;

   localparam logic [I1_W-1:0] I1_LAST = I1_W'(A_LEN - 1);
   localparam logic [I2_W-1:0] I2_LAST = I2_W'(B_LEN - 1);
   // First index at which seq2 expects b high
   localparam logic [I2_W-1:0] I2_HIGH = I2_W'(B_LOW);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   logic [0:0]      state;
   logic            start_q;
   logic            alive1;
   logic            alive2;
   logic [I1_W-1:0] idx1;
   logic [I2_W-1:0] idx2;

   logic            rise;
   logic            eval;
   logic            cur_alive1;
   logic            cur_alive2;
   logic [I1_W-1:0] cur_idx1;
   logic [I2_W-1:0] cur_idx2;
   logic            b_expect;
   logic            ok1;
   logic            ok2;
   logic            hit;
   logic            miss;
   logic            drop;

   assign rise = start & ~start_q;
   assign busy = (state == ACTIVE);

   // Matcher view for this edge: the trigger edge itself is evaluated with
   // freshly started matchers so E0 counts as the first sampled cycle.
   always_comb begin
      eval       = 1'b0;
      cur_alive1 = alive1;
      cur_alive2 = alive2;
      cur_idx1   = idx1;
      cur_idx2   = idx2;
      if (state == IDLE) begin
         eval       = rise;
         cur_alive1 = 1'b1;
         cur_alive2 = 1'b1;
         cur_idx1   = '0;
         cur_idx2   = '0;
      end else begin
         eval = 1'b1;
      end
      b_expect = (cur_idx2 >= I2_HIGH);
      ok1      = cur_alive1 & a;
      ok2      = cur_alive2 & (b == b_expect);
      // Any completion wins, even if the other matcher dies on this edge
      hit      = eval & ((ok1 & (cur_idx1 == I1_LAST)) | (ok2 & (cur_idx2 == I2_LAST)));
      miss     = eval & ~hit & ~ok1 & ~ok2;
      // A rise while active (including the deciding edge) is ignored
      drop     = (state == ACTIVE) & rise;
   end

   // Attempt state, sub-matcher progress and registered result pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         start_q <= 1'b0;
         alive1  <= 1'b0;
         alive2  <= 1'b0;
         idx1    <= '0;
         idx2    <= '0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         start_q <= start;
         pass    <= hit;
         fail    <= miss;
         if (hit || miss) begin
            state  <= IDLE;
            alive1 <= 1'b0;
            alive2 <= 1'b0;
         end else if (eval) begin
            state  <= ACTIVE;
            alive1 <= ok1;
            alive2 <= ok2;
            idx1   <= cur_idx1 + I1_W'(1);
            idx2   <= cur_idx2 + I2_W'(1);
         end
      end
   end

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (hit && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
         if (miss && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_or_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_or_seq_checker
// Purpose  : Self-checking bench for or_seq_checker (default parameters plus a
//            CNT_W=2 instance for counter saturation). Expected pulses are
//            queued when an attempt is driven and matched when they appear.
// Revision : 1.0  initial release
// ============================================================================
module tb_or_seq_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic       busy, pass, fail;
   logic [7:0] pass_cnt, fail_cnt, drop_cnt;
   logic       busy2, pass2, fail2;
   logic [1:0] pass_cnt2, fail_cnt2, drop_cnt2;

   int total = 0;
   int bad   = 0;
   int ecount = 0;
   int exp_pass = 0;
   int exp_fail = 0;
   int exp_drop = 0;

   typedef struct {
      logic [7:0] a_pat;
      logic [7:0] b_pat;
      int         d;
      bit         is_pass;
   } vec_t;

   typedef struct {
      int edge_n;
      bit is_pass;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t vecs[8];

   or_seq_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .pass(pass), .fail(fail),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt)
   );

   or_seq_checker #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy2), .pass(pass2), .fail(fail2),
      .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .drop_cnt(drop_cnt2)
   );

   always #5 clk = ~clk;

   // Posedge count; after edge N has happened ecount == N
   always @(posedge clk) ecount <= ecount + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Result pulse monitor: every pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (pass || fail) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pulse_unexpected: got pass=%0b fail=%0b at edge %0d want no pulse",
                     pass, fail, ecount);
         end else begin
            mon_e = sbq.pop_front();
            check("pulse_edge", ecount, mon_e.edge_n);
            check("pulse_pass", int'(pass), int'(mon_e.is_pass));
            check("pulse_fail", int'(fail), int'(!mon_e.is_pass));
         end
      end
   end

   // Inputs are sampled at the posedge inside this step
   task automatic step(input logic s, input logic av, input logic bv);
      start = s;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input int e0, input int d, input bit is_pass);
      exp_t e;
      e.edge_n  = e0 + d;
      e.is_pass = is_pass;
      sbq.push_back(e);
      if (is_pass) exp_pass++;
      else exp_fail++;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int busy_seen;
      int e0;
      busy_seen = 0;
      step(1'b0, 1'b0, 1'b0);
      e0 = ecount + 1;
      expect_pulse(e0, v.d, v.is_pass);
      for (int i = 0; i <= v.d; i++) begin
         step(1'b1, v.a_pat[i], v.b_pat[i]);
         if (busy) busy_seen++;
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check({name, "_busy_cycles"}, busy_seen, v.d);
   endtask

   task automatic check_counts(input string name);
      check({name, "_pass_cnt"}, int'(pass_cnt), exp_pass);
      check({name, "_fail_cnt"}, int'(fail_cnt), exp_fail);
      check({name, "_drop_cnt"}, int'(drop_cnt), exp_drop);
      check({name, "_queue_empty"}, sbq.size(), 0);
   endtask

   task automatic check_zero(input string name);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_pass"}, int'(pass), 0);
      check({name, "_fail"}, int'(fail), 0);
      check({name, "_cnts"}, int'(pass_cnt) + int'(fail_cnt) + int'(drop_cnt), 0);
   endtask

   initial begin
      int e0;
      // bit i of each pattern is the value at edge Ei
      vecs[0] = '{8'b0000_0011, 8'b0001_1000, 1, 1'b1}; // seq1 wins at E1
      vecs[1] = '{8'b0000_0001, 8'b0001_1000, 4, 1'b1}; // seq1 dies, seq2 at E4
      vecs[2] = '{8'b0000_0001, 8'b0000_1000, 4, 1'b0}; // seq2 dies at E4
      vecs[3] = '{8'b0000_0000, 8'b0000_0001, 0, 1'b0}; // both die at E0
      vecs[4] = '{8'b0000_0001, 8'b0000_0010, 1, 1'b0}; // both die at E1
      vecs[5] = '{8'b0000_0011, 8'b0000_0001, 1, 1'b1}; // seq2 dead at E0, seq1 wins
      vecs[6] = '{8'b0000_0000, 8'b0001_1000, 4, 1'b1}; // seq2 only
      vecs[7] = '{8'b0000_0000, 8'b0000_0100, 2, 1'b0}; // seq2 dies in low phase

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      check_zero("post_reset");

      // No trigger: nothing reported
      for (int i = 0; i < 4; i++) step(1'b0, 1'(i), 1'(i >> 1));
      check_counts("vacuous");

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
      check_counts("table");

      // Rises at E2 (busy) and at the deciding edge E4 are both dropped
      step(1'b0, 1'b0, 1'b0);
      e0 = ecount + 1;
      expect_pulse(e0, 4, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      exp_drop += 2;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_counts("drop");

      // Reset mid-attempt: silent abort, everything zero while low
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("mid_busy_before_reset", int'(busy), 1);
      rst_n = 1'b0;
      #2;
      check_zero("mid_reset");
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check_zero("mid_reset_held");
      rst_n = 1'b1;
      exp_pass = 0;
      exp_fail = 0;
      exp_drop = 0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_counts("after_reset");

      // Five passes: 8-bit counter reaches 5, 2-bit counter holds at 3
      for (int i = 0; i < 5; i++) run_vec(vecs[0], $sformatf("sat%0d", i));
      check_counts("sat");
      check("sat_pass_cnt2", int'(pass_cnt2), 3);
      check("sat_fail_cnt2", int'(fail_cnt2), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/or_seq_checker.md
Name: or_seq_checker

Overview:
- Synthesizable RTL monitor for the `$rose(start) |-> seq1 or seq2` check, with pass/fail pulses and counters for silicon/FPGA debug.
- seq1 = `a[*A_LEN]`; seq2 = `!b[*B_LOW] ##1 b[*B_HIGH]`.
- Sits downstream of the start/a/b stimulus source, in parallel with the SVA checker; results must match the SVA cycle for cycle.

Parameters:
- A_LEN, 2, consecutive cycles `a` must be high for seq1 (≥1).
- B_LOW, 3, consecutive cycles `b` must be low for seq2 (≥1).
- B_HIGH, 2, consecutive cycles `b` must be high after the low phase (≥1).
- CNT_W, 8, width of the saturating event counters.

Ports:
- clk  input  1  sampling clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  trigger; an attempt begins on a 0→1 transition sampled at posedge.
- a  input  1  seq1 operand.
- b  input  1  seq2 operand.
- busy  output  1  attempt in progress.
- pass  output  1  one-cycle pulse: attempt succeeded.
- fail  output  1  one-cycle pulse: attempt failed.
- pass_cnt  output  CNT_W  saturating count of passes.
- fail_cnt  output  CNT_W  saturating count of fails.
- drop_cnt  output  CNT_W  saturating count of triggers ignored while busy.

Behaviour:
- Reset (async assert, sync release): start_q=0, state IDLE, both sub-matchers dead; busy, pass, fail, and all counters = 0.
- Reset mid-attempt aborts the attempt silently: no pass or fail pulse.
- Edge numbering: E0 is the posedge where start=1 and start_q=0. Overlapping implication: E0 is the first sampled cycle of both sequences.
- IDLE → ACTIVE at E0.
  - seq1 matcher: alive, index 0. Checks a=1 at E0..E0+A_LEN-1; matches at E0+A_LEN-1.
  - seq2 matcher: alive, index 0. Checks b=0 at E0..E0+B_LOW-1, then b=1 at E0+B_LOW..E0+B_LOW+B_HIGH-1; matches at the last of these edges.
- A sub-matcher dies at the first edge whose sample mismatches its expected value.
- Per-edge resolution in ACTIVE (including E0):
  - Any alive matcher completes this edge → pass=1 next cycle, pass_cnt+1, go to IDLE. Applies even if the other matcher dies or matches on the same edge.
  - Otherwise, both matchers dead after this edge → fail=1 next cycle, fail_cnt+1, go to IDLE.
  - Net effect: pass is reported at the shorter successful match; fail is reported when the later matcher dies.
- pass and fail are registered: high for exactly the cycle following the deciding edge, never both high.
- A single-edge attempt is legal. Example: A_LEN=1 with a=1 at E0 → pass after E0.
- busy=1 from the edge after E0 up to and including the deciding edge. busy drops in the same cycle pass/fail rises.
- A start rise sampled while ACTIVE does not restart the attempt: drop_cnt+1, current attempt continues.
- A start rise sampled on the deciding edge itself is also dropped.
- start_q updates every edge regardless of state.
- Without a trigger, nothing is reported (vacuous successes are not counted).
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Counter widths for match indices: $clog2 of the respective lengths plus 1.

Test Plan:
- Defaults. start↑ with a=1 at E0,E1; b=0 at E0..E2, b=1 at E3,E4 → pass after E1 only (not again at E4); busy high for one cycle; pass_cnt=1, fail_cnt=0.
- a=1 at E0, a=0 at E1; b=0 at E0..E2, b=1 at E3,E4 → seq1 dies E1; pass after E4; busy high 4 cycles; pass_cnt=1.
- a=1 at E0, a=0 at E1; b=0 at E0..E2, b=1 at E3, b=0 at E4 → fail after E4 (not E1); fail_cnt=1.
- a=0 at E0 and b=1 at E0 → both die E0 → fail after E0; busy never asserts.
- Second start rise at E2 during a seq2-only attempt (start toggled 1→0→1) → drop_cnt=1; original attempt still resolves at E4. Separately: rst_n low at E2 of an attempt → no pulse; all outputs 0 while low; a fresh start↑ after release works normally.
- Saturation with CNT_W=2: 5 passing attempts → pass_cnt holds 3.
